// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the single-bus CPU datapath: word width, ALU operation
// indices and bus-source indices (lower index = higher bus priority).
package cpu_datapath_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int N_GPR      = 4;

    localparam int N_OPS   = 13;
    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_MUL  = 4;
    localparam int OP_DIV  = 5;
    localparam int OP_SHR  = 6;
    localparam int OP_SHRA = 7;
    localparam int OP_SHL  = 8;
    localparam int OP_ROR  = 9;
    localparam int OP_ROL  = 10;
    localparam int OP_NEG  = 11;
    localparam int OP_NOT  = 12;

    localparam int N_SRC      = 11;
    localparam int SRC_R0     = 0;
    localparam int SRC_R1     = 1;
    localparam int SRC_R2     = 2;
    localparam int SRC_PC     = 3;
    localparam int SRC_MDR    = 4;
    localparam int SRC_INPORT = 5;
    localparam int SRC_HI     = 6;
    localparam int SRC_LO     = 7;
    localparam int SRC_ZHI    = 8;
    localparam int SRC_ZLO    = 9;
    localparam int SRC_C      = 10;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: A is the RY latch, B is the bus. One-hot op select with
// priority to the lowest op index; the 2*WIDTH result feeds ZHI/ZLO.
module cpu_alu
    import cpu_datapath_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [N_OPS-1:0]   op,
    output logic [2*WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);

    logic signed [WIDTH-1:0]   a_s;
    logic signed [WIDTH-1:0]   b_s;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic        [SHW-1:0]     shamt;
    logic        [2*WIDTH-1:0] dbl_r;
    logic        [2*WIDTH-1:0] dbl_l;

    assign a_s   = a;
    assign b_s   = b;
    // Assigning signed to wider signed sign-extends, so the product is exact.
    assign a_ext = a_s;
    assign b_ext = b_s;
    assign prod  = a_ext * b_ext;
    assign shamt = b[SHW-1:0];
    assign dbl_r = {a, a} >> shamt;
    assign dbl_l = {a, a} << shamt;

    always_comb begin
        result = '0;
        if (op[OP_AND])       result[WIDTH-1:0] = a & b;
        else if (op[OP_OR])   result[WIDTH-1:0] = a | b;
        else if (op[OP_ADD])  result[WIDTH-1:0] = a + b;
        else if (op[OP_SUB])  result[WIDTH-1:0] = a - b;
        else if (op[OP_MUL])  result = prod;
        else if (op[OP_DIV]) begin
            // Divide by zero yields zero rather than an undefined value.
            if (b != '0) begin
                result[WIDTH-1:0]       = a_s / b_s;
                result[2*WIDTH-1:WIDTH] = a_s % b_s;
            end
        end
        else if (op[OP_SHR])  result[WIDTH-1:0] = a >> shamt;
        else if (op[OP_SHRA]) result[WIDTH-1:0] = a_s >>> shamt;
        else if (op[OP_SHL])  result[WIDTH-1:0] = a << shamt;
        else if (op[OP_ROR])  result[WIDTH-1:0] = dbl_r[WIDTH-1:0];
        else if (op[OP_ROL])  result[WIDTH-1:0] = dbl_l[2*WIDTH-1:WIDTH];
        else if (op[OP_NEG])  result[WIDTH-1:0] = -b;
        else if (op[OP_NOT])  result[WIDTH-1:0] = ~b;
    end

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: GPRs R0..R3, special registers, RY operand
// latch and ALU, all sequenced cycle-by-cycle by external one-hot selects.
module cpu_datapath #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  R0_select,
    input  logic                  R1_select,
    input  logic                  R2_select,
    input  logic                  PC_select,
    input  logic                  MDR_select,
    input  logic                  InPort_select,
    input  logic                  HI_select,
    input  logic                  LO_select,
    input  logic                  ZHI_select,
    input  logic                  ZLO_select,
    input  logic                  C_select,
    input  logic                  PC_select_write,
    input  logic                  MDR_select_write,
    input  logic                  MAR_select_write,
    input  logic                  InPort_select_write,
    input  logic                  OutPort_select_write,
    input  logic                  HI_select_write,
    input  logic                  LO_select_write,
    input  logic                  ZHI_select_write,
    input  logic                  ZLO_select_write,
    input  logic                  C_select_write,
    input  logic                  RY_select_write,
    input  logic                  RF_enable,
    input  logic [3:0]            RF_write,
    input  logic                  AND_select,
    input  logic                  OR_select,
    input  logic                  ADD_select,
    input  logic                  SUB_select,
    input  logic                  MUL_select,
    input  logic                  DIV_select,
    input  logic                  SHR_select,
    input  logic                  SHRA_select,
    input  logic                  SHL_select,
    input  logic                  ROR_select,
    input  logic                  ROL_select,
    input  logic                  NEG_select,
    input  logic                  NOT_select,
    input  logic [DATA_WIDTH-1:0] MDR_data,
    input  logic [DATA_WIDTH-1:0] IO_data_in,
    output logic [DATA_WIDTH-1:0] IO_data_out,
    output logic [DATA_WIDTH-1:0] MAR_data
);

    import cpu_datapath_pkg::*;

    logic [DATA_WIDTH-1:0]   gpr [N_GPR];
    logic [DATA_WIDTH-1:0]   pc, mdr, mar, inport, outport, hi, lo, zhi, zlo, c_reg, ry;
    logic [DATA_WIDTH-1:0]   bus;
    logic [N_SRC-1:0]        bus_sel;
    logic [DATA_WIDTH-1:0]   src_val [N_SRC];
    logic [N_OPS-1:0]        alu_op;
    logic [2*DATA_WIDTH-1:0] alu_res;

    assign bus_sel = {C_select, ZLO_select, ZHI_select, LO_select, HI_select,
                      InPort_select, MDR_select, PC_select, R2_select, R1_select,
                      R0_select};

    assign src_val[SRC_R0]     = gpr[0];
    assign src_val[SRC_R1]     = gpr[1];
    assign src_val[SRC_R2]     = gpr[2];
    assign src_val[SRC_PC]     = pc;
    assign src_val[SRC_MDR]    = mdr;
    assign src_val[SRC_INPORT] = inport;
    assign src_val[SRC_HI]     = hi;
    assign src_val[SRC_LO]     = lo;
    assign src_val[SRC_ZHI]    = zhi;
    assign src_val[SRC_ZLO]    = zlo;
    assign src_val[SRC_C]      = c_reg;

    // Scan from lowest priority upward so the lowest asserted index wins.
    always_comb begin
        bus = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (bus_sel[i]) bus = src_val[i];
        end
    end

    assign alu_op = {NOT_select, NEG_select, ROL_select, ROR_select, SHL_select,
                     SHRA_select, SHR_select, DIV_select, MUL_select, SUB_select,
                     ADD_select, OR_select, AND_select};

    cpu_alu #(
        .WIDTH (DATA_WIDTH)
    ) u_alu (
        .a      (ry),
        .b      (bus),
        .op     (alu_op),
        .result (alu_res)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < N_GPR; i++) gpr[i] <= '0;
            pc      <= '0;
            mdr     <= '0;
            mar     <= '0;
            inport  <= '0;
            outport <= '0;
            hi      <= '0;
            lo      <= '0;
            zhi     <= '0;
            zlo     <= '0;
            c_reg   <= '0;
            ry      <= '0;
        end else begin
            if (PC_select_write)      pc      <= bus;
            if (MDR_select_write)     mdr     <= MDR_data;
            if (MAR_select_write)     mar     <= bus;
            if (InPort_select_write)  inport  <= IO_data_in;
            if (OutPort_select_write) outport <= bus;
            if (HI_select_write)      hi      <= bus;
            if (LO_select_write)      lo      <= bus;
            if (ZHI_select_write)     zhi     <= alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
            if (ZLO_select_write)     zlo     <= alu_res[DATA_WIDTH-1:0];
            if (C_select_write)       c_reg   <= bus;
            if (RY_select_write)      ry      <= bus;
            if (RF_enable) begin
                for (int i = 0; i < N_GPR; i++) begin
                    if (RF_write[i]) gpr[i] <= bus;
                end
            end
        end
    end

    assign MAR_data    = mar;
    assign IO_data_out = outport;

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: register values are observed by routing
// them over the bus into MAR or OutPort and comparing against queued expectations.
module tb_cpu_datapath;
    import cpu_datapath_pkg::*;

    localparam int W_PC = 0, W_MDR = 1, W_MAR = 2, W_IN = 3, W_OUT = 4, W_HI = 5;
    localparam int W_LO = 6, W_ZHI = 7, W_ZLO = 8, W_C = 9, W_RY = 10;

    logic        clk = 1'b0;
    logic        clr;
    logic [10:0] sel;
    logic [10:0] wr;
    logic [12:0] op;
    logic        rf_en;
    logic [3:0]  rf_wr;
    logic [31:0] mdr_in, io_in;
    logic [31:0] io_out, mar_out;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    cpu_datapath #(.DATA_WIDTH(32)) dut (
        .clk                  (clk),
        .clr                  (clr),
        .R0_select            (sel[SRC_R0]),
        .R1_select            (sel[SRC_R1]),
        .R2_select            (sel[SRC_R2]),
        .PC_select            (sel[SRC_PC]),
        .MDR_select           (sel[SRC_MDR]),
        .InPort_select        (sel[SRC_INPORT]),
        .HI_select            (sel[SRC_HI]),
        .LO_select            (sel[SRC_LO]),
        .ZHI_select           (sel[SRC_ZHI]),
        .ZLO_select           (sel[SRC_ZLO]),
        .C_select             (sel[SRC_C]),
        .PC_select_write      (wr[W_PC]),
        .MDR_select_write     (wr[W_MDR]),
        .MAR_select_write     (wr[W_MAR]),
        .InPort_select_write  (wr[W_IN]),
        .OutPort_select_write (wr[W_OUT]),
        .HI_select_write      (wr[W_HI]),
        .LO_select_write      (wr[W_LO]),
        .ZHI_select_write     (wr[W_ZHI]),
        .ZLO_select_write     (wr[W_ZLO]),
        .C_select_write       (wr[W_C]),
        .RY_select_write      (wr[W_RY]),
        .RF_enable            (rf_en),
        .RF_write             (rf_wr),
        .AND_select           (op[OP_AND]),
        .OR_select            (op[OP_OR]),
        .ADD_select           (op[OP_ADD]),
        .SUB_select           (op[OP_SUB]),
        .MUL_select           (op[OP_MUL]),
        .DIV_select           (op[OP_DIV]),
        .SHR_select           (op[OP_SHR]),
        .SHRA_select          (op[OP_SHRA]),
        .SHL_select           (op[OP_SHL]),
        .ROR_select           (op[OP_ROR]),
        .ROL_select           (op[OP_ROL]),
        .NEG_select           (op[OP_NEG]),
        .NOT_select           (op[OP_NOT]),
        .MDR_data             (mdr_in),
        .IO_data_in           (io_in),
        .IO_data_out          (io_out),
        .MAR_data             (mar_out)
    );

    function automatic logic [10:0] b11(input int i);
        return 11'(1) << i;
    endfunction

    function automatic logic [12:0] b13(input int i);
        return 13'(1) << i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One control cycle: drive, take the rising edge, then release all controls.
    task automatic step(input logic [10:0] s, input logic [10:0] w, input logic [12:0] o,
                        input logic rfe, input logic [3:0] rfw);
        sel = s; wr = w; op = o; rf_en = rfe; rf_wr = rfw;
        @(posedge clk);
        #1;
        sel = '0; wr = '0; op = '0; rf_en = 1'b0; rf_wr = '0;
    endtask

    task automatic read_sel(input logic [10:0] s, input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        step(s, b11(W_MAR), '0, 1'b0, 4'b0);
        chk(tag_q.pop_front(), mar_out, exp_q.pop_front());
    endtask

    task automatic read_src(input int src, input string tag, input logic [31:0] exp);
        read_sel(b11(src), tag, exp);
    endtask

    task automatic read_out(input int src, input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        step(b11(src), b11(W_OUT), '0, 1'b0, 4'b0);
        chk(tag_q.pop_front(), io_out, exp_q.pop_front());
    endtask

    task automatic put_in(input logic [31:0] v);
        io_in = v;
        step('0, b11(W_IN), '0, 1'b0, 4'b0);
    endtask

    task automatic set_gpr(input int i, input logic [31:0] v);
        put_in(v);
        step(b11(SRC_INPORT), '0, '0, 1'b1, 4'(1) << i);
    endtask

    task automatic set_ry(input logic [31:0] v);
        put_in(v);
        step(b11(SRC_INPORT), b11(W_RY), '0, 1'b0, 4'b0);
    endtask

    task automatic alu_r0(input logic [12:0] o);
        step(b11(SRC_R0), b11(W_ZHI) | b11(W_ZLO), o, 1'b0, 4'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = '0; wr = '0; op = '0; rf_en = 1'b0; rf_wr = '0;
        mdr_in = '0; io_in = '0;
        clr = 1'b1;
        #2 clr = 1'b0;
        #1;
        chk("rst_mar", mar_out, 32'h0);
        chk("rst_out", io_out, 32'h0);
        #4 clr = 1'b1;
        @(posedge clk); #1;

        read_src(SRC_R0, "rst_r0", 32'h0);
        read_src(SRC_R1, "rst_r1", 32'h0);
        read_src(SRC_R2, "rst_r2", 32'h0);
        read_src(SRC_PC, "rst_pc", 32'h0);
        read_src(SRC_MDR, "rst_mdr", 32'h0);
        read_src(SRC_INPORT, "rst_in", 32'h0);
        read_src(SRC_HI, "rst_hi", 32'h0);
        read_src(SRC_LO, "rst_lo", 32'h0);
        read_src(SRC_ZHI, "rst_zhi", 32'h0);
        read_src(SRC_ZLO, "rst_zlo", 32'h0);
        read_src(SRC_C, "rst_c", 32'h0);

        put_in(32'd5);
        read_src(SRC_INPORT, "inport5", 32'd5);
        step(b11(SRC_INPORT), '0, '0, 1'b1, 4'b0001);
        put_in(32'd3);
        step(b11(SRC_INPORT), '0, '0, 1'b1, 4'b0010);
        read_src(SRC_R0, "r0_5", 32'd5);
        read_src(SRC_R1, "r1_3", 32'd3);

        put_in(32'd9);
        step(b11(SRC_INPORT), '0, '0, 1'b0, 4'b0001);
        read_src(SRC_R0, "rf_en_off", 32'd5);

        step(b11(SRC_R1), b11(W_RY), '0, 1'b0, 4'b0);
        alu_r0(b13(OP_AND));
        read_src(SRC_ZLO, "and_lo", 32'd1);
        read_src(SRC_ZHI, "and_hi", 32'd0);
        alu_r0(b13(OP_OR));
        read_src(SRC_ZLO, "or_lo", 32'd7);
        alu_r0(b13(OP_ADD));
        read_src(SRC_ZLO, "add_lo", 32'd8);
        alu_r0(b13(OP_SUB));
        read_src(SRC_ZLO, "sub_lo", 32'hFFFF_FFFE);
        alu_r0(b13(OP_AND) | b13(OP_ADD));
        read_src(SRC_ZLO, "op_prio", 32'd1);
        alu_r0('0);
        read_src(SRC_ZLO, "no_op", 32'd0);

        set_ry(32'hFFFF_FFFA);
        set_gpr(0, 32'd4);
        alu_r0(b13(OP_MUL));
        read_src(SRC_ZHI, "mul_hi", 32'hFFFF_FFFF);
        read_src(SRC_ZLO, "mul_lo", 32'hFFFF_FFE8);
        alu_r0(b13(OP_DIV));
        read_src(SRC_ZLO, "div_q", 32'hFFFF_FFFF);
        read_src(SRC_ZHI, "div_r", 32'hFFFF_FFFE);
        set_gpr(0, 32'd0);
        alu_r0(b13(OP_DIV));
        read_src(SRC_ZLO, "div0_lo", 32'd0);
        read_src(SRC_ZHI, "div0_hi", 32'd0);

        set_ry(32'h8000_0001);
        set_gpr(0, 32'd1);
        alu_r0(b13(OP_SHR));  read_src(SRC_ZLO, "shr", 32'h4000_0000);
        alu_r0(b13(OP_SHRA)); read_src(SRC_ZLO, "shra", 32'hC000_0000);
        alu_r0(b13(OP_SHL));  read_src(SRC_ZLO, "shl", 32'h0000_0002);
        alu_r0(b13(OP_ROR));  read_src(SRC_ZLO, "ror", 32'hC000_0000);
        alu_r0(b13(OP_ROL));  read_src(SRC_ZLO, "rol", 32'h0000_0003);
        set_gpr(0, 32'h24);
        alu_r0(b13(OP_SHR));  read_src(SRC_ZLO, "shr4", 32'h0800_0000);
        alu_r0(b13(OP_ROL));  read_src(SRC_ZLO, "rol4", 32'h0000_0018);

        set_gpr(0, 32'd5);
        alu_r0(b13(OP_NEG));  read_src(SRC_ZLO, "neg", 32'hFFFF_FFFB);
        alu_r0(b13(OP_NOT));  read_src(SRC_ZLO, "not", 32'hFFFF_FFFA);
        read_out(SRC_ZLO, "outport", 32'hFFFF_FFFA);

        mdr_in = 32'h0000_1234;
        step('0, b11(W_MDR), '0, 1'b0, 4'b0);
        read_src(SRC_MDR, "mdr", 32'h0000_1234);

        set_gpr(2, 32'h0000_00AA);
        read_src(SRC_R2, "r2", 32'h0000_00AA);
        step(b11(SRC_R2), b11(W_HI) | b11(W_PC), '0, 1'b0, 4'b0);
        set_gpr(2, 32'h0000_00CC);
        step(b11(SRC_R2), b11(W_C) | b11(W_LO), '0, 1'b0, 4'b0);
        read_src(SRC_HI, "hi", 32'h0000_00AA);
        read_src(SRC_LO, "lo", 32'h0000_00CC);
        read_src(SRC_C, "c", 32'h0000_00CC);
        read_sel(b11(SRC_R0) | b11(SRC_PC), "prio_r0_pc", 32'd5);
        read_sel(b11(SRC_HI) | b11(SRC_C), "prio_hi_c", 32'h0000_00AA);
        read_sel('0, "bus_idle", 32'h0);

        read_src(SRC_PC, "pc", 32'h0000_00AA);
        sel = b11(SRC_R0); wr = b11(W_PC);
        #2 clr = 1'b0;
        #1;
        chk("mid_rst_mar", mar_out, 32'h0);
        chk("mid_rst_out", io_out, 32'h0);
        @(posedge clk); #1;
        sel = '0; wr = '0;
        clr = 1'b1;
        read_src(SRC_PC, "post_rst_pc", 32'h0);
        read_src(SRC_R0, "post_rst_r0", 32'h0);
        read_sel('0, "post_rst_bus", 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
